tcp_tx_scheduler: RTL

- Shares one TCP segment encoder between N transmit requesters (connections) using round-robin arbitration.
- Per segment, it grants one requester, pulses the encoder start, and streams that requester's payload words into the encoder.
- It then waits for the encoder's finish, reports the checksum and length to the granted requester, and pulses an encoder reset. The encoder's finish state is sticky until reset.
- Sits between per-connection TX queues and the encoder, upstream of the IP framer.

---
 rtl/tcp_tx_scheduler_pkg.sv | 24 ++
 rtl/tcp_tx_scheduler_if.sv | 21 ++
 rtl/tcp_tx_scheduler_rr_arbiter.sv | 38 +++
 rtl/tcp_tx_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tcp_tx_scheduler_pkg.sv
// Shared types and helpers for the TCP transmit scheduler and its arbiter.
// Word-count helper converts a byte length into encoder payload words.
package tcp_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR    = 3'd0,
        ST_IDLE     = 3'd1,
        ST_START    = 3'd2,
        ST_STREAM   = 3'd3,
        ST_WAIT_FIN = 3'd4,
        ST_REPORT   = 3'd5
    } tx_state_e;

    localparam int TCP_WORD_BYTES = 4;
    localparam int WORDS_W        = 15;

    // ceil(len/4); the 17-bit sum keeps 0xFFFF from wrapping to zero words
    function automatic logic [WORDS_W-1:0] words_from_len(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd3;
        return sum[16:2];
    endfunction

endpackage

// File: rtl/tcp_tx_scheduler_if.sv
// Scheduler-to-encoder connection: start/reset control, payload stream and result.
interface tcp_tx_scheduler_if;
    logic        enc_start;
    logic        enc_reset;
    logic [15:0] enc_len_in;
    logic [31:0] enc_data;
    logic        enc_data_av;
    logic        enc_fin;
    logic [15:0] enc_checksum;
    logic [15:0] enc_len_out;

    modport master (
        output enc_start, enc_reset, enc_len_in, enc_data, enc_data_av,
        input  enc_fin, enc_checksum, enc_len_out
    );

    modport slave (
        input  enc_start, enc_reset, enc_len_in, enc_data, enc_data_av,
        output enc_fin, enc_checksum, enc_len_out
    );
endinterface

// File: rtl/tcp_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
// The pointer register lives in the parent so the RX side can reuse this.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             any
);

    // scan N_REQ positions starting at ptr; the first hit wins
    always_comb begin
        int idx;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx[IDW-1:0];
                any      = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/tcp_tx_scheduler.sv
// Round-robin sharing of one TCP segment encoder between N_REQ transmit queues:
// grant, start, stream payload, wait for finish (bounded), report, reset encoder.
module tcp_tx_scheduler
    import tcp_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [16*N_REQ-1:0] req_len,
    input  logic [32*N_REQ-1:0] src_data,
    input  logic [N_REQ-1:0]    src_valid,
    output logic [N_REQ-1:0]    src_ready,
    output logic [N_REQ-1:0]    grant,
    output logic [IDW-1:0]      grant_id,
    output logic [N_REQ-1:0]    done,
    output logic [N_REQ-1:0]    err,
    output logic [15:0]         res_checksum,
    output logic [15:0]         res_len,
    output logic                res_valid,
    tcp_tx_scheduler_if.master  enc
);

    localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    tx_state_e          state_r, next_s;
    logic [N_REQ-1:0]   grant_r;
    logic [IDW-1:0]     grant_id_r;
    logic [IDW-1:0]     rr_ptr_r;
    logic [15:0]        enc_len_in_r;
    logic [WORDS_W-1:0] words_left_r;
    logic [TMO_W-1:0]   tmo_r;
    logic [15:0]        res_checksum_r;
    logic [15:0]        res_len_r;
    logic               res_valid_r;
    logic [N_REQ-1:0]   done_r;
    logic [N_REQ-1:0]   err_r;
    logic               enc_start_r;
    logic               enc_reset_r;

    logic [N_REQ-1:0]   arb_gnt_s;
    logic [IDW-1:0]     arb_id_s;
    logic               arb_any_s;
    logic               owner_valid_s;
    logic               tmo_hit_s;
    logic               grant_take_s;
    logic               abort_s;
    logic [IDW-1:0]     ptr_next_s;
    logic [15:0]        arb_len_s;
    logic [N_REQ-1:0]   src_ready_s;
    logic [31:0]        enc_data_s;
    logic               enc_data_av_s;
    logic               enc_start_nxt_s;
    logic               enc_reset_nxt_s;
    logic [N_REQ-1:0]   done_nxt_s;
    logic [N_REQ-1:0]   err_nxt_s;

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .req    (req),
        .ptr    (rr_ptr_r),
        .gnt    (arb_gnt_s),
        .gnt_id (arb_id_s),
        .any    (arb_any_s)
    );

    assign owner_valid_s = (state_r == ST_STREAM) && src_valid[grant_id_r];
    assign tmo_hit_s     = (tmo_r == TMO_W'(TIMEOUT));
    assign grant_take_s  = (state_r == ST_IDLE) && (next_s == ST_START);
    assign abort_s       = (state_r == ST_WAIT_FIN) && (next_s == ST_CLEAR);
    assign ptr_next_s    = (grant_id_r == IDW'(N_REQ - 1)) ? {IDW{1'b0}} : grant_id_r + IDW'(1);
    assign arb_len_s     = req_len[16*arb_id_s +: 16];

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= next_s;
        end
    end

    // next-state logic; enc_fin is only honoured in WAIT_FIN
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_CLEAR:    next_s = ST_IDLE;
            ST_IDLE:     next_s = arb_any_s ? ST_START : ST_IDLE;
            ST_START:    next_s = (words_left_r != {WORDS_W{1'b0}}) ? ST_STREAM : ST_WAIT_FIN;
            ST_STREAM: begin
                if (owner_valid_s && (words_left_r == WORDS_W'(1))) begin
                    next_s = ST_WAIT_FIN;
                end else begin
                    next_s = ST_STREAM;
                end
            end
            ST_WAIT_FIN: begin
                if (enc.enc_fin) begin
                    next_s = ST_REPORT;
                end else if (tmo_hit_s) begin
                    next_s = ST_CLEAR;
                end else begin
                    next_s = ST_WAIT_FIN;
                end
            end
            ST_REPORT:   next_s = ST_CLEAR;
            default:     next_s = ST_CLEAR;
        endcase
    end

    // output logic: live payload path plus next values of the registered pulses
    always_comb begin
        src_ready_s     = '0;
        enc_data_s      = src_data[32*grant_id_r +: 32];
        enc_data_av_s   = owner_valid_s;
        if (state_r == ST_STREAM) begin
            src_ready_s[grant_id_r] = src_valid[grant_id_r];
        end else begin
            src_ready_s = '0;
        end
        enc_start_nxt_s = (next_s == ST_START);
        enc_reset_nxt_s = (next_s == ST_CLEAR);
        done_nxt_s      = (next_s == ST_REPORT) ? grant_r : {N_REQ{1'b0}};
        err_nxt_s       = abort_s ? grant_r : {N_REQ{1'b0}};
    end

    // ownership, latched length and remaining word count
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r      <= '0;
            grant_id_r   <= '0;
            enc_len_in_r <= 16'd0;
            words_left_r <= '0;
        end else if (grant_take_s) begin
            grant_r      <= arb_gnt_s;
            grant_id_r   <= arb_id_s;
            enc_len_in_r <= arb_len_s;
            words_left_r <= words_from_len(arb_len_s);
        end else if (next_s == ST_CLEAR) begin
            grant_r      <= '0;
            grant_id_r   <= '0;
        end else if (owner_valid_s) begin
            words_left_r <= words_left_r - WORDS_W'(1);
        end else begin
            words_left_r <= words_left_r;
        end
    end

    // encoder control and owner notification pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_start_r <= 1'b0;
            enc_reset_r <= 1'b1;
            done_r      <= '0;
            err_r       <= '0;
            res_valid_r <= 1'b0;
        end else begin
            enc_start_r <= enc_start_nxt_s;
            enc_reset_r <= enc_reset_nxt_s;
            done_r      <= done_nxt_s;
            err_r       <= err_nxt_s;
            res_valid_r <= (next_s == ST_REPORT);
        end
    end

    // result capture, finish timeout and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            res_checksum_r <= 16'd0;
            res_len_r      <= 16'd0;
            tmo_r          <= '0;
            rr_ptr_r       <= '0;
        end else begin
            if ((state_r == ST_WAIT_FIN) && enc.enc_fin) begin
                res_checksum_r <= enc.enc_checksum;
                res_len_r      <= enc.enc_len_out;
            end else begin
                res_checksum_r <= res_checksum_r;
                res_len_r      <= res_len_r;
            end
            if ((state_r == ST_WAIT_FIN) && !enc.enc_fin && !tmo_hit_s) begin
                tmo_r <= tmo_r + TMO_W'(1);
            end else begin
                tmo_r <= '0;
            end
            if ((state_r == ST_REPORT) || abort_s) begin
                rr_ptr_r <= ptr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign src_ready       = src_ready_s;
    assign grant           = grant_r;
    assign grant_id        = grant_id_r;
    assign done            = done_r;
    assign err             = err_r;
    assign res_checksum    = res_checksum_r;
    assign res_len         = res_len_r;
    assign res_valid       = res_valid_r;
    assign enc.enc_start   = enc_start_r;
    assign enc.enc_reset   = enc_reset_r;
    assign enc.enc_len_in  = enc_len_in_r;
    assign enc.enc_data    = enc_data_s;
    assign enc.enc_data_av = enc_data_av_s;

endmodule
